// File: rtl/encrypter_scheduler_if.sv
// Bundle of upstream, lane-fanout and collector signals around encrypter_scheduler.
// slave = scheduler side, master = environment (upstream, lanes, collector).
`ifndef ENCRYPTER_WIDTH
`define ENCRYPTER_WIDTH 32
`endif
`ifndef KEY_ROTATION_WIDTH
`define KEY_ROTATION_WIDTH 5
`endif

interface encrypter_scheduler_if #(
  parameter int N_LANES = 4,
  parameter int DATA_W  = `ENCRYPTER_WIDTH,
  parameter int ROT_W   = `KEY_ROTATION_WIDTH
);
  logic [DATA_W-1:0]         in_data;
  logic [ROT_W-1:0]          in_rot;
  logic                      in_prog;
  logic                      in_valid;
  logic                      in_ready;

  logic [DATA_W-1:0]         lane_data;
  logic [ROT_W-1:0]          lane_rot;
  logic [N_LANES-1:0]        lane_prog;
  logic [N_LANES-1:0]        lane_dready;
  logic [N_LANES-1:0]        lane_ready;
  logic [N_LANES*DATA_W-1:0] lane_out;
  logic [N_LANES-1:0]        lane_oready;
  logic [N_LANES-1:0]        lane_capture;

  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;

  logic [31:0]               stat_words;
  logic [31:0]               stat_stalls;

  modport slave (
    input  in_data, in_rot, in_prog, in_valid,
    output in_ready,
    output lane_data, lane_rot, lane_prog, lane_dready,
    input  lane_ready, lane_out, lane_oready,
    output lane_capture,
    output out_data, out_valid,
    input  out_ready,
    output stat_words, stat_stalls
  );

  modport master (
    output in_data, in_rot, in_prog, in_valid,
    input  in_ready,
    input  lane_data, lane_rot, lane_prog, lane_dready,
    output lane_ready, lane_out, lane_oready,
    input  lane_capture,
    input  out_data, out_valid,
    output out_ready,
    input  stat_words, stat_stalls
  );
endinterface

// File: rtl/encrypter_scheduler.sv
// Round-robin dispatch of words/keys over N_LANES Encrypters with in-order collection; SCHED_STATS_EN adds counters.
// Latency: accept at T -> lane_dready at T+1; lane result -> out_valid one cycle after lane_oready is seen.
// Backpressure: out_valid held while out_ready=0 (no capture); in_ready drops when target lane busy or N_LANES outstanding.
`ifndef ENCRYPTER_WIDTH
`define ENCRYPTER_WIDTH 32
`endif
`ifndef KEY_ROTATION_WIDTH
`define KEY_ROTATION_WIDTH 5
`endif

module encrypter_scheduler #(
  parameter int N_LANES = 4,
  parameter int DATA_W  = `ENCRYPTER_WIDTH,
  parameter int ROT_W   = `KEY_ROTATION_WIDTH
) (
  input logic clk,
  input logic reset,
  encrypter_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(N_LANES);
  localparam int CNT_W = $clog2(N_LANES + 1);
  localparam logic [CNT_W-1:0]   FULL  = CNT_W'(N_LANES);
  localparam logic [N_LANES-1:0] LANE0 = N_LANES'(1);

  typedef enum logic [1:0] {IDLE, KEY_DRAIN, KEY_LOAD, RUN} state_t;

  state_t             state;
  logic [PTR_W-1:0]   dptr;
  logic [PTR_W-1:0]   cptr;
  logic [CNT_W-1:0]   outstanding;
  logic [N_LANES-1:0] busy_clr;
  logic               load_cnt;

  logic [DATA_W-1:0]  lane_data_q;
  logic [ROT_W-1:0]   lane_rot_q;
  logic [N_LANES-1:0] lane_prog_q;
  logic [N_LANES-1:0] lane_dready_q;
  logic [N_LANES-1:0] lane_capture_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_valid_q;

  logic               in_rdy;
  logic               acc_key;
  logic               acc_data;
  logic               capture;
  logic [DATA_W-1:0]  cap_word;

  // Keys are taken in RUN regardless of lane state: the drain phase waits out old work.
  always_comb begin
    in_rdy = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    in_rdy = bus.in_prog;
        RUN:     in_rdy = bus.in_prog | (bus.lane_ready[dptr] & (outstanding < FULL));
        default: in_rdy = 1'b0;
      endcase
    end
  end

  assign acc_key  = bus.in_valid & in_rdy & bus.in_prog;
  assign acc_data = bus.in_valid & in_rdy & ~bus.in_prog;
  assign cap_word = bus.lane_out[int'(cptr)*DATA_W +: DATA_W];
  assign capture  = (outstanding != '0) & bus.lane_oready[cptr] & ~busy_clr[cptr]
                  & (~out_valid_q | bus.out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      dptr           <= '0;
      cptr           <= '0;
      outstanding    <= '0;
      busy_clr       <= '0;
      load_cnt       <= 1'b0;
      lane_data_q    <= '0;
      lane_rot_q     <= '0;
      lane_prog_q    <= '0;
      lane_dready_q  <= '0;
      lane_capture_q <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
    end else begin
      lane_dready_q  <= '0;
      lane_capture_q <= '0;

      if (acc_key | acc_data) begin
        lane_data_q <= bus.in_data;
        lane_rot_q  <= bus.in_rot;
      end

      if (acc_data) begin
        lane_dready_q <= LANE0 << dptr;
        dptr          <= dptr + 1'b1;
      end

      case ({acc_data, capture})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      // A captured lane keeps lane_oready high until it sees the strobe; ignore it until it drops.
      for (int i = 0; i < N_LANES; i++) begin
        if (!bus.lane_oready[i]) busy_clr[i] <= 1'b0;
      end

      if (capture) begin
        busy_clr[cptr] <= 1'b1;
        out_data_q     <= cap_word;
        out_valid_q    <= 1'b1;
        lane_capture_q <= LANE0 << cptr;
        cptr           <= cptr + 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state)
        IDLE, RUN: begin
          if (acc_key) state <= KEY_DRAIN;
        end
        KEY_DRAIN: begin
          if (outstanding == '0) begin
            state       <= KEY_LOAD;
            lane_prog_q <= '1;
            load_cnt    <= 1'b0;
          end
        end
        KEY_LOAD: begin
          if (load_cnt) begin
            lane_prog_q <= '0;
            state       <= RUN;
          end else begin
            load_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_rdy;
  assign bus.lane_data    = lane_data_q;
  assign bus.lane_rot     = lane_rot_q;
  assign bus.lane_prog    = lane_prog_q;
  assign bus.lane_dready  = lane_dready_q;
  assign bus.lane_capture = lane_capture_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;

`ifdef SCHED_STATS_EN
  logic [31:0] words_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (out_valid_q && bus.out_ready && (words_q != '1)) words_q <= words_q + 1'b1;
      if (bus.in_valid && !in_rdy && (stalls_q != '1)) stalls_q <= stalls_q + 1'b1;
    end
  end

  assign bus.stat_words  = words_q;
  assign bus.stat_stalls = stalls_q;
`else
  assign bus.stat_words  = '0;
  assign bus.stat_stalls = '0;
`endif

endmodule

// File: tb/tb_encrypter_scheduler.sv
// Bench for encrypter_scheduler: behavioural lanes plus an in-order queue of expected results.
module tb_encrypter_scheduler;
  localparam int NL = 4;
  localparam int DW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  encrypter_scheduler_if #(.N_LANES(NL), .DATA_W(DW), .ROT_W(RW)) bus();
  encrypter_scheduler #(.N_LANES(NL), .DATA_W(DW), .ROT_W(RW)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] expq[$];
  logic [DW-1:0] m_key;
  int m_dptr   = 0;
  int accepted = 0;
  int emitted  = 0;
  bit rnd_or   = 1'b0;
  bit hold     = 1'b0;
  logic [DW-1:0] hold_data;

  logic [NL-1:0] l_busy, l_oready, block;
  logic [DW-1:0] l_key[NL];
  logic [DW-1:0] l_res[NL];
  int l_cnt[NL];
  int extra[NL];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] x, input logic [RW-1:0] r);
    int s;
    s = int'(r) % DW;
    if (s == 0) return x;
    return (x << s) | (x >> (DW - s));
  endfunction

  // Lanes: latch key on lane_prog, compute after a random delay, hold result until captured.
  assign bus.lane_ready  = ~l_busy & ~block;
  assign bus.lane_oready = l_oready;
  assign bus.lane_out    = {l_res[3], l_res[2], l_res[1], l_res[0]};

  always @(posedge clk) begin
    if (reset) begin
      l_busy   <= '0;
      l_oready <= '0;
      for (int i = 0; i < NL; i++) begin
        l_res[i] <= '0;
        l_cnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (bus.lane_prog[i]) l_key[i] <= bus.lane_data;
        if (bus.lane_capture[i]) begin
          if (!l_oready[i]) check("capture_no_result", l_oready[i], 1);
          l_oready[i] <= 1'b0;
          l_busy[i]   <= 1'b0;
        end else if (bus.lane_dready[i]) begin
          if (l_busy[i]) check("dready_busy_lane", l_busy[i], 0);
          l_busy[i] <= 1'b1;
          l_res[i]  <= bus.lane_data ^ rotl(l_key[i], bus.lane_rot);
          l_cnt[i]  <= $urandom_range(0, 4) + extra[i];
        end else if (l_busy[i] && !l_oready[i]) begin
          if (l_cnt[i] == 0) l_oready[i] <= 1'b1;
          else l_cnt[i] <= l_cnt[i] - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_or) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: order/value against the queue, hold stability, one-hot strobes.
  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, hold_data);
        check("hold_no_capture", bus.lane_capture, 0);
      end
      hold      = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) check("unexpected_out", bus.out_valid, 0);
        else begin
          check("out_data", bus.out_data, expq.pop_front());
          emitted++;
        end
      end
      if (bus.lane_dready != 0) check("dready_onehot", $onehot(bus.lane_dready), 1);
      if (bus.lane_capture != 0) check("capture_onehot", $onehot(bus.lane_capture), 1);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_oready(input logic v);
    @(posedge clk);
    #1;
    bus.out_ready = v;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [RW-1:0] r, input logic p);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_data = d; bus.in_rot = r; bus.in_prog = p; bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    accepted++;
    if (p) m_key = d;
    else expq.push_back(d ^ rotl(m_key, r));
    #1;
    bus.in_valid = 1'b0;
    if (p) begin
      check("key_latch", bus.lane_data, d);
      check("key_no_dready", bus.lane_dready, 0);
    end else begin
      check("dready_latency", bus.lane_dready, NL'(1) << m_dptr);
      check("lane_word", bus.lane_data, d);
      m_dptr = (m_dptr + 1) % NL;
      @(posedge clk);
      #1;
      check("dready_one_cycle", bus.lane_dready, 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", expq.size(), 0);
    wait_cycles(10);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_lane_data", bus.lane_data, 0);
    check("rst_lane_rot", bus.lane_rot, 0);
    check("rst_lane_prog", bus.lane_prog, 0);
    check("rst_lane_dready", bus.lane_dready, 0);
    check("rst_lane_capture", bus.lane_capture, 0);
    check("rst_stat_words", bus.stat_words, 0);
    check("rst_stat_stalls", bus.stat_stalls, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_prog = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    expq.delete();
    m_dptr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1;
    bus.in_data = '0; bus.in_rot = '0; bus.in_prog = 1'b1; bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    block = '0;
    for (int i = 0; i < NL; i++) extra[i] = 0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;

    // IDLE accepts only keys
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_prog = 1'b0;
    #1 check("idle_data_ready", bus.in_ready, 0);
    bus.in_prog = 1'b1;
    #1 check("idle_key_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0;

    // key then 8 words with rotations 0..7
    send(32'hA5A5A5A5, 0, 1'b1);
    for (int i = 1; i <= 8; i++) send(DW'(i), RW'(i - 1), 1'b0);
    drain();

    // downstream stalled for 50 cycles while 8 words are offered
    set_oready(1'b0);
    base = accepted;
    fork
      for (int i = 0; i < 8; i++) send($urandom, RW'($urandom_range(0, 31)), 1'b0);
      begin
        wait_cycles(50);
        #2;
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_accepted", accepted - base, 5);
        set_oready(1'b1);
      end
    join
    drain();

    // lane 2 slow: order must hold
    extra[2] = 30;
    for (int i = 0; i < NL; i++) send(32'h100 + DW'(i), RW'(i), 1'b0);
    drain();
    extra[2] = 0;

    // key change with 3 words outstanding
    for (int i = 0; i < NL; i++) extra[i] = 20;
    for (int i = 0; i < 3; i++) send(32'h2000 + DW'(i), RW'(3 * i), 1'b0);
    base = emitted;
    send(32'h0F0F0F0F, 0, 1'b1);
    begin
      int n;
      n = 0;
      while (bus.lane_prog == 0 && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    check("old_results_before_prog", emitted - base, 3);
    check("prog_cycle1", bus.lane_prog, 4'hF);
    @(negedge clk);
    check("prog_cycle2", bus.lane_prog, 4'hF);
    @(negedge clk);
    check("prog_cycle3", bus.lane_prog, 0);
    for (int i = 0; i < NL; i++) extra[i] = 0;
    send(32'h12345678, 5'd9, 1'b0);
    drain();

    // randomized traffic with random downstream backpressure and occasional key changes
    rnd_or = 1'b1;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NL; i++) extra[i] = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) send($urandom, 0, 1'b1);
      else send($urandom, RW'($urandom_range(0, 31)), 1'b0);
    end
    rnd_or = 1'b0;
    set_oready(1'b1);
    for (int i = 0; i < NL; i++) extra[i] = 0;
    drain();

    // reset with 2 words in flight
    for (int i = 0; i < NL; i++) extra[i] = 30;
    send(32'hDEAD0001, 1, 1'b0);
    send(32'hDEAD0002, 2, 1'b0);
    reset_dut();
    for (int i = 0; i < NL; i++) extra[i] = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_prog = 1'b0; bus.in_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1 check("nokey_in_ready", bus.in_ready, 0);
      check("nokey_out_valid", bus.out_valid, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_cycles(40);
    check("discarded_out_valid", bus.out_valid, 0);

    // statistics: 10 words plus 5 forced stall cycles
    reset_dut();
    send(32'hC0FFEE00, 0, 1'b1);
    wait_cycles(10);
    for (int i = 0; i < 10; i++) begin
      send(32'h3000 + DW'(i), RW'(i), 1'b0);
      wait_cycles(12);
    end
    @(negedge clk);
    block = '1;
    bus.in_data = 32'h77; bus.in_prog = 1'b0; bus.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    block = '0;
    drain();
`ifdef SCHED_STATS_EN
    check("stat_words", bus.stat_words, 10);
    check("stat_stalls", bus.stat_stalls, 5);
`else
    check("stat_words", bus.stat_words, 0);
    check("stat_stalls", bus.stat_stalls, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/encrypter_scheduler.md
ENCRYPTER_SCHEDULER -- requirements
Module: encrypter_scheduler

Interface
REQ-001 Parameter N_LANES, default 4, number of Encrypter lanes shared (2..8, power of two).
REQ-002 Parameter DATA_W, default `ENCRYPTER_WIDTH, word and key width.
REQ-003 Parameter ROT_W, default `KEY_ROTATION_WIDTH, rotation field width.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 in_data  in  DATA_W  upstream word, or key when in_prog=1.
REQ-007 in_rot  in  ROT_W  rotation amount for in_data.
REQ-008 in_prog  in  1  qualifies in_data as a new key.
REQ-009 in_valid  in  1  upstream word present.
REQ-010 in_ready  out  1  scheduler accepts in_data this cycle.
REQ-011 lane_data  out  DATA_W  registered word/key broadcast to all lanes.
REQ-012 lane_rot  out  ROT_W  registered rotation broadcast to all lanes.
REQ-013 lane_prog  out  N_LANES  per-lane key-program strobe.
REQ-014 lane_dready  out  N_LANES  per-lane data-ready strobe.
REQ-015 lane_ready  in  N_LANES  per-lane ready from Encrypters.
REQ-016 lane_out  in  N_LANES*DATA_W  lane i result at bits [i*DATA_W +: DATA_W].
REQ-017 lane_oready  in  N_LANES  per-lane result valid.
REQ-018 lane_capture  out  N_LANES  per-lane capture strobe.
REQ-019 out_data  out  DATA_W  in-order result to collector.
REQ-020 out_valid  out  1  out_data valid; held until out_ready.
REQ-021 out_ready  in  1  downstream accepts out_data.
REQ-022 stat_words, stat_stalls  out  32 each  statistics counters (see Configuration).

Function
REQ-023 FSM states IDLE, KEY_DRAIN, KEY_LOAD, RUN; reset -> IDLE.
REQ-024 IDLE: in_ready=1 only for in_prog words; data words are not accepted before a key has been loaded.
REQ-025 Key accepted (in_valid & in_prog & in_ready) in IDLE or RUN -> KEY_DRAIN; in_data latched into lane_data.
REQ-026 KEY_DRAIN: in_ready=0; remain until outstanding count = 0, then -> KEY_LOAD.
REQ-027 KEY_LOAD: lane_prog all ones for exactly 2 cycles (covers Encrypter IDLE->READING_KEY), then -> RUN.
REQ-028 RUN dispatch: in_ready = ~in_prog-pending & lane_ready[dptr] & (outstanding < N_LANES); on accept latch data/rot, pulse lane_dready[dptr] for exactly 1 cycle next cycle, dptr <= dptr+1 mod N_LANES.
REQ-029 Dispatch latency: accept at cycle T -> lane_dready[dptr] high at cycle T+1 only.
REQ-030 Collect: cptr round-robin, independent of dptr; results emitted strictly in dispatch order.
REQ-031 When lane_oready[cptr]=1 and (out_valid=0 or out_ready=1) and lane not marked busy-clear: load out_data, set out_valid, pulse lane_capture[cptr] 1 cycle, mark lane busy-clear, cptr++.
REQ-032 Busy-clear lane is ineligible for collection until its lane_oready observed 0.
REQ-033 Outstanding count 0..N_LANES: +1 on dispatch, -1 on capture; simultaneous dispatch and capture leave it unchanged.
REQ-034 out_valid & ~out_ready: out_data stable, no capture issued.
REQ-035 in_prog word in RUN with work outstanding: all pending results still emitted with the old key before KEY_LOAD.
REQ-036 At most one lane_dready and one lane_capture bit high in any cycle.

Reset
REQ-037 On reset: state IDLE, dptr=cptr=0, outstanding=0, busy-clear flags=0, in_ready=0 for the reset cycle.
REQ-038 Reset values: lane_data=0, lane_rot=0, lane_prog=0, lane_dready=0, lane_capture=0, out_data=0, out_valid=0, stat counters=0.
REQ-039 Reset mid-operation discards in-flight words; a new key is required before data is accepted.

Configuration
REQ-040 Macro SCHED_STATS_EN defined: stat_words +1 per emitted result; stat_stalls +1 per cycle with in_valid=1 and in_ready=0; both saturate at 2^32-1.
REQ-041 SCHED_STATS_EN undefined: stat_words and stat_stalls tied to 0 and no counter logic is compiled in.

Verification
REQ-042 Key 0xA5A5A5A5 then words 0x1..0x8, rot 0..7, out_ready=1 -> outputs 0x1^rotl(key,0) .. 0x8^rotl(key,7), in order.
REQ-043 out_ready=0 for 50 cycles with 8 words sent -> out_valid held, first result stable, outstanding reaches 4, in_ready=0; release -> all 8 emitted in order.
REQ-044 Lane 2 result delayed 30 cycles vs lanes 0,1,3 -> output order remains lane 0,1,2,3.
REQ-045 New key 0x0F0F0F0F injected with 3 outstanding -> 3 old-key results emitted before lane_prog pulses; next word uses new key.
REQ-046 Reset asserted with 2 words outstanding -> all outputs 0 next cycle; data word without a key not accepted (in_ready=0).
REQ-047 With SCHED_STATS_EN, 10 words plus 5 forced stall cycles -> stat_words=10, stat_stalls=5; without the macro both read 0.
